// File: rtl/division_fixed_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | division_fixed_param: sequential scaled fixed-point divider (1b/clk) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module division_fixed_param #(
  parameter int N        = 16,
  parameter int S        = 3,
  parameter int OUT_FRAC = 3,
  parameter int ROUND    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic         overFlow,
  output logic         divideByZero
);

  localparam int M    = N - S;
  localparam int SMAX = (1 << S) - 1;
  localparam int W    = M + SMAX + OUT_FRAC;
  localparam int ITER = W + ROUND;
  localparam int D    = M + SMAX;
  localparam int RW   = D + 2;
  localparam int QW   = ITER + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIX    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_rem;
  logic [ITER-1:0] r_q;
  logic [D-1:0]    r_d;
  logic [CW-1:0]   r_cnt;
  logic            r_sa;
  logic            r_sb;
  logic            r_az;

  logic [S-1:0]    w_fa, w_fb, w_sha, w_shb;
  logic [M-1:0]    w_ma, w_mb, w_amag, w_bmag;
  logic [ITER-1:0] w_a_al;
  logic [D-1:0]    w_b_al;

  assign w_fa   = dividend[N-1:M];
  assign w_fb   = divisor[N-1:M];
  assign w_ma   = dividend[M-1:0];
  assign w_mb   = divisor[M-1:0];
  // Magnitudes stay unsigned M bits so that |-2^(M-1)| is exact.
  assign w_amag = w_ma[M-1] ? (~w_ma + M'(1)) : w_ma;
  assign w_bmag = w_mb[M-1] ? (~w_mb + M'(1)) : w_mb;
  assign w_sha  = (w_fb > w_fa) ? (w_fb - w_fa) : '0;
  assign w_shb  = (w_fa > w_fb) ? (w_fa - w_fb) : '0;
  assign w_a_al = (ITER'(w_amag) << w_sha) << (OUT_FRAC + ROUND);
  assign w_b_al = D'(w_bmag) << w_shb;

  logic [RW-1:0] w_dext, w_rs, w_rn;

  assign w_dext = RW'(r_d);
  assign w_rs   = {r_rem[RW-2:0], r_q[ITER-1]};
  assign w_rn   = r_rem[RW-1] ? (w_rs + w_dext) : (w_rs - w_dext);

  logic [QW-1:0] w_qraw, w_qmag, w_lim_neg, w_lim_pos;
  logic          w_neg, w_ovf;
  logic [M-1:0]  w_qm, w_sat, w_mant, w_dz_mant;

  assign w_qraw = QW'(r_q);

  generate
    if (ROUND != 0) begin : g_round
      assign w_qmag = (w_qraw >> 1) + QW'(r_q[0]);
    end else begin : g_trunc
      assign w_qmag = w_qraw;
    end
  endgenerate

  assign w_lim_neg = QW'(1) << (M - 1);
  assign w_lim_pos = w_lim_neg - QW'(1);
  assign w_neg     = (r_sa ^ r_sb) && (w_qmag != '0);
  assign w_ovf     = w_neg ? (w_qmag > w_lim_neg) : (w_qmag > w_lim_pos);
  assign w_qm      = w_qmag[M-1:0];
  assign w_sat     = w_neg ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
  assign w_mant    = w_ovf ? w_sat : (w_neg ? (~w_qm + M'(1)) : w_qm);
  assign w_dz_mant = r_az ? '0 :
                     (r_sa ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      Q            <= '0;
      overFlow     <= 1'b0;
      divideByZero <= 1'b0;
      r_rem        <= '0;
      r_q          <= '0;
      r_d          <= '0;
      r_cnt        <= '0;
      r_sa         <= 1'b0;
      r_sb         <= 1'b0;
      r_az         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa         <= w_ma[M-1];
            r_sb         <= w_mb[M-1];
            r_az         <= (w_ma == '0);
            r_q          <= w_a_al;
            r_d          <= w_b_al;
            r_rem        <= '0;
            r_cnt        <= CW'(ITER);
            overFlow     <= 1'b0;
            divideByZero <= (w_mb == '0);
            busy         <= 1'b1;
            r_state      <= (w_mb == '0) ? S_FIX : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          // Quotient bit is 1 whenever the updated remainder is non-negative.
          r_rem <= w_rn;
          r_q   <= {r_q[ITER-2:0], ~w_rn[RW-1]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (divideByZero) begin
            Q <= {S'(OUT_FRAC), w_dz_mant};
          end else begin
            Q        <= {S'(OUT_FRAC), w_mant};
            overFlow <= w_ovf;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_division_fixed_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_division_fixed_param: three divider configurations vs arithmetic  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_division_fixed_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st0, st1, st2;
  logic [15:0] a0, b0, a1, b1, q0, q1;
  logic [23:0] a2, b2, q2;
  logic        bz0, dn0, of0, dz0;
  logic        bz1, dn1, of1, dz1;
  logic        bz2, dn2, of2, dz2;

  division_fixed_param #(.N(16), .S(3), .OUT_FRAC(3), .ROUND(0)) u_dut0 (
    .clk(clk), .reset(rst), .start(st0), .dividend(a0), .divisor(b0),
    .busy(bz0), .done(dn0), .Q(q0), .overFlow(of0), .divideByZero(dz0));

  division_fixed_param #(.N(16), .S(3), .OUT_FRAC(3), .ROUND(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(st1), .dividend(a1), .divisor(b1),
    .busy(bz1), .done(dn1), .Q(q1), .overFlow(of1), .divideByZero(dz1));

  division_fixed_param #(.N(24), .S(4), .OUT_FRAC(5), .ROUND(1)) u_dut2 (
    .clk(clk), .reset(rst), .start(st2), .dividend(a2), .divisor(b2),
    .busy(bz2), .done(dn2), .Q(q2), .overFlow(of2), .divideByZero(dz2));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] dq[3];
  logic        ddn[3], dbz[3], dof[3], ddz[3];
  assign dq[0] = {8'h00, q0};
  assign dq[1] = {8'h00, q1};
  assign dq[2] = q2;
  assign ddn[0] = dn0; assign ddn[1] = dn1; assign ddn[2] = dn2;
  assign dbz[0] = bz0; assign dbz[1] = bz1; assign dbz[2] = bz2;
  assign dof[0] = of0; assign dof[1] = of1; assign dof[2] = of2;
  assign ddz[0] = dz0; assign ddz[1] = dz1; assign ddz[2] = dz2;

  bit          pend[3];
  int          s_cyc[3], busy_cnt[3], elat[3];
  logic [23:0] eq[3];
  bit          eo[3], ez[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void cfg(input int k, output int n, output int s, output int of, output int r);
    case (k)
      0:       begin n = 16; s = 3; of = 3; r = 0; end
      1:       begin n = 16; s = 3; of = 3; r = 1; end
      default: begin n = 24; s = 4; of = 5; r = 1; end
    endcase
  endfunction

  // Reference: exact rational quotient of the two scaled values, rescaled to OUT_FRAC.
  function automatic logic [63:0] model(input int n, input int s, input int of, input int r,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output bit ovf, output bit dz);
    int     m, sh;
    longint one, ma, mb, fa, fb, num, den, q, mant, lim;
    bit     neg;
    m   = n - s;
    one = 1;
    fa  = longint'((a >> m) & 64'((one << s) - 1));
    fb  = longint'((b >> m) & 64'((one << s) - 1));
    ma  = longint'(a & 64'((one << m) - 1));
    mb  = longint'(b & 64'((one << m) - 1));
    if (ma >= (one << (m - 1))) ma = ma - (one << m);
    if (mb >= (one << (m - 1))) mb = mb - (one << m);
    lim = one << (m - 1);
    ovf = 1'b0;
    dz  = 1'b0;
    if (mb == 0) begin
      dz   = 1'b1;
      mant = (ma == 0) ? 0 : ((ma < 0) ? -lim : lim - 1);
    end else begin
      num = (ma < 0) ? -ma : ma;
      den = (mb < 0) ? -mb : mb;
      sh  = int'(fb) - int'(fa) + of + r;
      if (sh >= 0) num = num << sh;
      else         den = den << (-sh);
      q = num / den;
      if (r != 0) q = (q + 1) / 2;
      neg = ((ma < 0) != (mb < 0)) && (q != 0);
      if (neg ? (q > lim) : (q > lim - 1)) begin
        ovf  = 1'b1;
        mant = neg ? -lim : lim - 1;
      end else begin
        mant = neg ? -q : q;
      end
    end
    return (64'(of) << m) | (64'(mant) & 64'((one << m) - 1));
  endfunction

  function automatic int model_lat(input int n, input int s, input int of, input int r, input bit dz);
    return dz ? 1 : (n - s) + ((1 << s) - 1) + of + r + 1;
  endfunction

  // Single compare process: every done pulse is checked against the expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k] && dbz[k] === 1'b1) busy_cnt[k]++;
      if (ddn[k] === 1'b1) begin
        if (!pend[k]) begin
          checks++;
          errors++;
          $display("FAIL spurious_done dut%0d: done=1, expected 0", k);
        end else begin
          chk($sformatf("Q dut%0d", k), 64'(dq[k]), 64'(eq[k]));
          chk($sformatf("overFlow dut%0d", k), 64'(dof[k]), 64'(eo[k]));
          chk($sformatf("divideByZero dut%0d", k), 64'(ddz[k]), 64'(ez[k]));
          chk($sformatf("latency dut%0d", k), 64'(cyc - s_cyc[k]), 64'(elat[k]));
          chk($sformatf("busy_cycles dut%0d", k), 64'(busy_cnt[k]), 64'(elat[k]));
          pend[k] = 1'b0;
        end
      end
    end
  end

  task automatic launch(input int k, input logic [23:0] a, input logic [23:0] b);
    int n, s, of, r;
    bit o, z;
    logic [63:0] e;
    cfg(k, n, s, of, r);
    e = model(n, s, of, r, 64'(a), 64'(b), o, z);
    @(negedge clk);
    case (k)
      0:       begin a0 = a[15:0]; b0 = b[15:0]; st0 = 1'b1; end
      1:       begin a1 = a[15:0]; b1 = b[15:0]; st1 = 1'b1; end
      default: begin a2 = a;       b2 = b;       st2 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    eq[k]       = e[23:0];
    eo[k]       = o;
    ez[k]       = z;
    elat[k]     = model_lat(n, s, of, r, z);
    s_cyc[k]    = cyc;
    busy_cnt[k] = 0;
    pend[k]     = 1'b1;
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    while (pend[k] && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (pend[k]) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: no done within %0d cycles, expected done", k, t);
      pend[k] = 1'b0;
    end
  endtask

  task automatic run(input int k, input logic [23:0] a, input logic [23:0] b);
    launch(k, a, b);
    wait_done(k);
  endtask

  localparam int NV0 = 13;
  logic [15:0] va0[NV0] = '{16'h200C, 16'h0001, 16'h1FFD, 16'h0001, 16'h0005, 16'h1FFB,
                            16'h0FFF, 16'h1001, 16'h0000, 16'h1FFD, 16'h0000, 16'h1000, 16'h1000};
  logic [15:0] vb0[NV0] = '{16'h2003, 16'h4001, 16'h0002, 16'h0003, 16'h4000, 16'h4000,
                            16'h4001, 16'h4001, 16'h4000, 16'h1FFE, 16'h1FFF, 16'h0008, 16'h1FF8};
  logic [15:0] vq0[NV0] = '{16'h6020, 16'h6020, 16'h7FF4, 16'h6002, 16'h6FFF, 16'h7000,
                            16'h6FFF, 16'h7000, 16'h6000, 16'h600C, 16'h6000, 16'h7000, 16'h6FFF};
  localparam int NV1 = 4;
  logic [15:0] va1[NV1] = '{16'h0001, 16'h1FFF, 16'h0001, 16'h200C};
  logic [15:0] vb1[NV1] = '{16'h0003, 16'h0003, 16'h0010, 16'h2003};
  logic [15:0] vq1[NV1] = '{16'h6003, 16'h7FFD, 16'h6001, 16'h6020};

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit o, z;
    int dcount;
    int t;
    logic [23:0] ra, rb, msk, mmsk;
    int n, s, of, r;

    rst = 1'b1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_Q dut%0d", k), 64'(dq[k]), 64'h0);
      chk($sformatf("reset_flags dut%0d", k), 64'({dbz[k], ddn[k], dof[k], ddz[k]}), 64'h0);
    end
    rst = 1'b0;

    // Hand-derived values pin the reference model.
    for (int i = 0; i < NV0; i++)
      chk($sformatf("model_pin0_%0d", i), model(16, 3, 3, 0, 64'(va0[i]), 64'(vb0[i]), o, z), 64'(vq0[i]));
    for (int i = 0; i < NV1; i++)
      chk($sformatf("model_pin1_%0d", i), model(16, 3, 3, 1, 64'(va1[i]), 64'(vb1[i]), o, z), 64'(vq1[i]));
    void'(model(16, 3, 3, 0, 64'h0FFF, 64'h4001, o, z));
    chk("model_pin_ovf", 64'({o, z}), 64'h2);
    void'(model(16, 3, 3, 0, 64'h0005, 64'h4000, o, z));
    chk("model_pin_dz", 64'({o, z}), 64'h1);
    chk("model_pin_lat", 64'(model_lat(16, 3, 3, 0, 1'b0)), 64'd24);
    chk("model_pin_lat_r", 64'(model_lat(16, 3, 3, 1, 1'b0)), 64'd25);

    for (int i = 0; i < NV0; i++) run(0, 24'(va0[i]), 24'(vb0[i]));
    for (int i = 0; i < NV1; i++) run(1, 24'(va1[i]), 24'(vb1[i]));

    // Start pulsed mid-operation must not disturb the running division.
    launch(0, 24'h200C, 24'h2003);
    repeat (5) @(posedge clk);
    @(negedge clk);
    a0 = 16'h0005; b0 = 16'h4000; st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    wait_done(0);

    // Start held during the DONE cycle is ignored.
    launch(0, 24'h0001, 24'h0003);
    t = 0;
    while (dn0 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    a0 = 16'h200C; b0 = 16'h2003; st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    @(negedge clk);
    chk("start_in_done_busy", 64'(bz0), 64'h0);
    wait_done(0);

    // Reset part-way through an operation.
    launch(0, 24'h200C, 24'h2003);
    repeat (10) @(posedge clk);
    @(negedge clk);
    pend[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_Q", 64'(q0), 64'h0);
    chk("abort_flags", 64'({bz0, dn0, of0, dz0}), 64'h0);
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (dn0 === 1'b1) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'h0);
    run(0, 24'h1FFD, 24'h0002);

    for (int k = 0; k < 3; k++) begin
      cfg(k, n, s, of, r);
      msk  = 24'((64'd1 << n) - 1);
      mmsk = 24'((64'd1 << (n - s)) - 1);
      for (int i = 0; i < ((k == 2) ? 30 : 12); i++) begin
        ra = 24'($urandom) & msk;
        rb = 24'($urandom) & msk;
        if ($urandom_range(0, 9) == 0) rb = rb & ~mmsk;
        if ($urandom_range(0, 3) == 0) rb = (rb & ~mmsk) | (24'($urandom_range(1, 16)) & mmsk);
        run(k, ra, rb);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
